mem64_writeback: RTL and testbench
==================================

Name: mem64_writeback

Overview:
- Write-back engine for 8x8 blocks of DW-bit words; the opposite direction of the block-fetch path that loads SRAM words into a local 64-entry buffer.
- Upstream compute stages deposit the block one row (8 words) at a time into an internal 64xDW buffer.
- On start, the block streams out to SRAM as 64 sequential single-word writes from a base address.
- The block then pulses done.

Parameters:
- AW, 18, SRAM address width.
- DW, 16, word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- row_wr  in  1  write row_data into buffer row row_idx (accepted only in IDLE).
- row_idx  in  3  destination row 0..7.
- row_data  in  8*DW  row words; column 0 in bits [8*DW-1 -: DW], column 7 in bits [DW-1:0].
- start  in  1  begin write-back (sampled only in IDLE).
- base_addr  in  AW  SRAM address of word 0; latched on the accepted start.
- w_addr  out  AW  SRAM write address.
- w_data  out  DW  SRAM write data.
- w_en  out  1  SRAM write strobe; one word per cycle while asserted.
- busy  out  1  high in WRITE and DONE.
- done  out  1  single-cycle pulse after the last word is written.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, k=0, base_q=0.
  - w_en=0, busy=0, done=0; w_addr=0.
  - Buffer contents are not reset and are undefined until written.
- Buffer organisation: word (r,c) lives at index k = r*8 + c, where "*8" is a shift of r by 3 concatenated with c. This is a 6-bit index; the operators must not be used in a way that drops the shift.
- Row write:
  - In IDLE, row_wr=1 writes all 8 words of row row_idx at the clock edge.
  - row_wr in WRITE or DONE is ignored; the buffer is not modified.
- State machine, states IDLE, WRITE, DONE:
  - IDLE: start=1 -> WRITE, base_q<=base_addr, k<=0.
  - WRITE: k==63 (and the word completes) -> DONE; otherwise k<=k+1.
  - DONE: -> IDLE unconditionally; done=1 for exactly this cycle.
- Outputs:
  - w_en = (state==WRITE).
  - w_addr = base_q + k, truncated to AW bits; wraps modulo 2^AW.
  - w_data = buf[k].
  - All outputs are derived from registers only; there is no combinational path from any input to any output.
- Latency: start sampled at edge t gives:
  - first w_en cycle from t to t+1;
  - 64 consecutive w_en cycles;
  - done high in cycle 65 after t;
  - IDLE again, ready for start, one cycle later.
- Boundary conditions:
  - row_wr and start in the same IDLE cycle: the row write commits at the same edge and its data IS included in the write-back.
  - start while busy: ignored and not queued.
  - Row written twice before start: last write wins.
  - Rows never written: their words are sent as undefined buffer contents.
  - base_addr near 2^AW-1: the address wraps to 0 and continues.
  - Reset asserted mid-WRITE: w_en drops immediately and no further writes occur; the partial block stays in SRAM.

Optional Feature:
- Macro: SRAM_READY_EN.
- Defined:
  - Adds input w_ready (1 bit).
  - In WRITE, a word completes only in a cycle with w_en=1 and w_ready=1; k advances only then.
  - While w_ready=0, w_en stays 1 and w_addr/w_data stay stable.
  - The DONE transition requires k==63 and w_ready=1.
  - Total write cycles = 64 + stall cycles.
- Undefined: the w_ready port does not exist and every WRITE cycle completes a word.

Decomposition:
- Shared package mem64_pkg holds:
  - state encoding localparams: IDLE=2'd0, WRITE=2'd1, DONE=2'd2;
  - BLK_WORDS=64, ROW_WORDS=8, IDX_W=6, ROW_IDX_W=3.
- The fetch block reuses the same package constants.
- One natural sub-module: mem64_buf.
  - 64xDW register array with an 8-word row write port (row_wr, row_idx, row_data).
  - One asynchronous word read port indexed by k.
- The FSM, the k counter and the address adder stay in mem64_writeback.

Test Plan:
- Fill rows 0..7 with word(r,c)=16'h0100*r+c; start with base_addr=18'h00400 -> 64 consecutive w_en cycles:
  - addresses 0x00400..0x0043F;
  - data 0x0000..0x0707 in row-major order;
  - done one cycle after the last write; busy high throughout.
- Same cycle row_wr (row 0 = all 16'hBEEF) and start -> the first 8 writes carry 16'hBEEF.
- base_addr=18'h3FFFE -> the first writes go to 0x3FFFE, 0x3FFFF, 0x00000, ...; the last write goes to 0x0003D.
- row_wr (row 3 = 16'h1111) and start pulses during WRITE -> no buffer change, no restart; exactly 64 writes and one done.
- Reset asserted at the 10th write -> w_en=0 in the same cycle, state IDLE; a new start afterwards performs a full 64-word write-back.
- With SRAM_READY_EN: hold w_ready=0 for 3 cycles at k=5 -> w_addr=base+5 and w_data held stable; 67 w_en cycles in total; done still follows the last accepted word.

Source files
------------

// File: rtl/mem64_pkg.sv
// Shared constants and state encoding for the 8x8 block fetch / write-back paths.
package mem64_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BLK_WORDS = 64;
  localparam int ROW_WORDS = 8;
  localparam int IDX_W     = 6;
  localparam int ROW_IDX_W = 3;
  localparam int COL_W     = IDX_W - ROW_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_WRITE = WRITE,
    ST_DONE  = DONE
  } state_e;

endpackage

// File: rtl/mem64_buf.sv
// 64-word block buffer: one 8-word row write port, one asynchronous word read port.
// Contents are deliberately not reset.
module mem64_buf
  import mem64_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                    clock,
  input  logic                    wr_en_i,
  input  logic [ROW_IDX_W-1:0]    row_idx_i,
  input  logic [ROW_WORDS*DW-1:0] row_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DW-1:0]           rd_data_o
);

  logic [DW-1:0] mem_q [BLK_WORDS];

  // Column 0 sits in the most significant word of the row bus.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int c = 0; c < ROW_WORDS; c++) begin
        mem_q[{row_idx_i, COL_W'(c)}] <= row_data_i[(ROW_WORDS-1-c)*DW +: DW];
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mem64_writeback.sv
// Streams a buffered 8x8 block to SRAM as 64 sequential single-word writes.
// Optional SRAM_READY_EN adds a w_ready handshake that stalls the stream.
module mem64_writeback
  import mem64_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    row_wr,
  input  logic [ROW_IDX_W-1:0]    row_idx,
  input  logic [ROW_WORDS*DW-1:0] row_data,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
`ifdef SRAM_READY_EN
  input  logic                    w_ready,
`endif
  output logic [AW-1:0]           w_addr,
  output logic [DW-1:0]           w_data,
  output logic                    w_en,
  output logic                    busy,
  output logic                    done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [AW-1:0]    base_q, base_d;
  logic             word_done;

`ifdef SRAM_READY_EN
  assign word_done = w_ready;
`else
  assign word_done = 1'b1;
`endif

  mem64_buf #(.DW(DW)) u_buf (
    .clock      (clock),
    .wr_en_i    (row_wr && (state_q == ST_IDLE)),
    .row_idx_i  (row_idx),
    .row_data_i (row_data),
    .rd_idx_i   (k_q),
    .rd_data_o  (w_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          base_d  = base_addr;
          k_d     = '0;
        end
      end
      ST_WRITE: begin
        if (word_done) begin
          if (k_q == IDX_W'(BLK_WORDS - 1)) state_d = ST_DONE;
          else k_d = k_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything below depends on registers only, so no input reaches an output.
  assign w_en   = (state_q == ST_WRITE);
  assign busy   = (state_q == ST_WRITE) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign w_addr = base_q + AW'(k_q);

endmodule

// File: tb/tb_mem64_writeback.sv
// Randomized self-checking bench for mem64_writeback against a row/word array model.
module tb_mem64_writeback;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          row_wr = 1'b0;
  logic [2:0]    row_idx = '0;
  logic [127:0]  row_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
`ifdef SRAM_READY_EN
  logic          w_ready = 1'b1;
`endif
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_en, busy, done;

  int testsRun  = 0;
  int failCount = 0;

  logic [15:0] model [64];
  logic [17:0] gotAddr [$];
  logic [15:0] gotData [$];
  int doneCnt, doneIdx, lastWenIdx, firstWenIdx, busyLow;

  mem64_writeback #(.AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_wr    (row_wr),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .start     (start),
    .base_addr (base_addr),
`ifdef SRAM_READY_EN
    .w_ready   (w_ready),
`endif
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_en      (w_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] expAddr(input logic [17:0] base, input int i);
    return 18'((int'(base) + i) % 262144);
  endfunction

  task automatic writeRow(input int r, input logic [127:0] d);
    @(negedge clock);
    row_wr = 1'b1; row_idx = 3'(r); row_data = d;
    @(negedge clock);
    row_wr = 1'b0;
    for (int c = 0; c < 8; c++) model[r*8 + c] = d[(7-c)*16 +: 16];
  endtask

  function automatic logic [127:0] randRow();
    logic [127:0] d;
    for (int c = 0; c < 8; c++) d[(7-c)*16 +: 16] = 16'($urandom);
    return d;
  endfunction

  // Starts a block and records every w_en cycle until one cycle past done.
  task automatic runBlock(input logic [17:0] base, input bit poke, input bit sameRow,
                          input logic [127:0] rowVal, input int stallAt, input int stallLen);
    int cyc = 0;
    int stallLeft = stallLen;
    int accepted = 0;
    gotAddr.delete(); gotData.delete();
    doneCnt = 0; doneIdx = -1; lastWenIdx = -1; firstWenIdx = -1; busyLow = 0;
    @(negedge clock);
    start = 1'b1; base_addr = base;
    row_wr = sameRow; row_idx = 3'd0; row_data = rowVal;
    @(negedge clock);
    start = 1'b0; row_wr = 1'b0;
    while (doneIdx < 0 && cyc < 300) begin
      if (w_en) begin
        if (firstWenIdx < 0) firstWenIdx = cyc;
        lastWenIdx = cyc;
        gotAddr.push_back(w_addr);
        gotData.push_back(w_data);
      end
      if (done) begin doneCnt++; doneIdx = cyc; end
      if (doneCnt == 0 && !busy) busyLow++;
`ifdef SRAM_READY_EN
      if (w_en && accepted == stallAt && stallLeft > 0) begin
        w_ready = 1'b0; stallLeft--;
      end else w_ready = 1'b1;
      if (w_en && w_ready) accepted++;
`endif
      if (poke && cyc >= 3 && cyc < 6) begin
        start = 1'b1; row_wr = 1'b1; row_idx = 3'd3; row_data = {8{16'h1111}};
        base_addr = 18'($urandom);
      end else begin
        start = 1'b0; row_wr = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; row_wr = 1'b0;
`ifdef SRAM_READY_EN
    w_ready = 1'b1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    testsRun++;
    if (w_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_addr !== 18'h0) begin
      failCount++;
      $display("[TB] FAIL reset: w_en=%b busy=%b done=%b w_addr=%h, expected 0 0 0 00000",
               w_en, busy, done, w_addr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    testsRun++;
    if (w_en !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: w_en=%b busy=%b, expected 0 0", w_en, busy);
    end
  endtask

  task automatic test_fill_and_write();
    logic [127:0] d;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) d[(7-c)*16 +: 16] = 16'(16'h0100 * r + c);
      writeRow(r, d);
    end
    runBlock(18'h00400, 1'b0, 1'b0, '0, -1, 0);
    testsRun++;
    if (gotAddr.size() !== 64 || firstWenIdx !== 0) begin
      failCount++;
      $display("[TB] FAIL fill_count: %0d writes first at %0d, expected 64 at 0",
               gotAddr.size(), firstWenIdx);
    end
    for (int i = 0; i < gotAddr.size() && i < 64; i++) begin
      testsRun++;
      if (gotAddr[i] !== expAddr(18'h00400, i) ||
          gotData[i] !== 16'(16'h0100 * (i / 8) + (i % 8))) begin
        failCount++;
        $display("[TB] FAIL fill_word%0d: addr=%h data=%h, expected addr=%h data=%h", i,
                 gotAddr[i], gotData[i], expAddr(18'h00400, i), 16'(16'h0100*(i/8) + (i%8)));
      end
    end
    testsRun++;
    if (doneCnt !== 1 || doneIdx !== lastWenIdx + 1 || busyLow !== 0) begin
      failCount++;
      $display("[TB] FAIL fill_done: done %0d at %0d last write %0d busy-low %0d, expected 1 pulse after last write, busy-low 0",
               doneCnt, doneIdx, lastWenIdx, busyLow);
    end
    testsRun++;
    if (busy !== 1'b0 || w_en !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fill_idle: busy=%b w_en=%b, expected 0 0", busy, w_en);
    end
  endtask

  task automatic test_same_cycle();
    logic [17:0] b = 18'($urandom);
    runBlock(b, 1'b0, 1'b1, {8{16'hBEEF}}, -1, 0);
    for (int c = 0; c < 8; c++) model[c] = 16'hBEEF;
    testsRun++;
    if (gotAddr.size() !== 64 || doneCnt !== 1) begin
      failCount++;
      $display("[TB] FAIL same_count: %0d writes %0d done, expected 64 and 1", gotAddr.size(), doneCnt);
    end
    for (int i = 0; i < gotAddr.size() && i < 64; i++) begin
      testsRun++;
      if (gotAddr[i] !== expAddr(b, i) || gotData[i] !== model[i]) begin
        failCount++;
        $display("[TB] FAIL same_word%0d: addr=%h data=%h, expected addr=%h data=%h", i,
                 gotAddr[i], gotData[i], expAddr(b, i), model[i]);
      end
    end
  endtask

  task automatic test_wrap();
    runBlock(18'h3FFFE, 1'b0, 1'b0, '0, -1, 0);
    testsRun++;
    if (gotAddr.size() !== 64) begin
      failCount++;
      $display("[TB] FAIL wrap_count: %0d writes, expected 64", gotAddr.size());
    end else begin
      testsRun++;
      if (gotAddr[0] !== 18'h3FFFE || gotAddr[1] !== 18'h3FFFF || gotAddr[2] !== 18'h00000 ||
          gotAddr[63] !== 18'h0003D) begin
        failCount++;
        $display("[TB] FAIL wrap_addr: %h %h %h last %h, expected 3fffe 3ffff 00000 last 0003d",
                 gotAddr[0], gotAddr[1], gotAddr[2], gotAddr[63]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [17:0] b = 18'($urandom);
    int extra = 0;
    runBlock(b, 1'b1, 1'b0, '0, -1, 0);
    testsRun++;
    if (gotAddr.size() !== 64 || doneCnt !== 1) begin
      failCount++;
      $display("[TB] FAIL busy_count: %0d writes %0d done, expected 64 and 1", gotAddr.size(), doneCnt);
    end
    repeat (5) begin
      if (w_en) extra++;
      @(negedge clock);
    end
    testsRun++;
    if (extra !== 0) begin
      failCount++;
      $display("[TB] FAIL busy_restart: %0d extra writes, expected 0", extra);
    end
    runBlock(b, 1'b0, 1'b0, '0, -1, 0);
    for (int i = 0; i < gotAddr.size() && i < 64; i++) begin
      testsRun++;
      if (gotAddr[i] !== expAddr(b, i) || gotData[i] !== model[i]) begin
        failCount++;
        $display("[TB] FAIL busy_word%0d: addr=%h data=%h, expected addr=%h data=%h", i,
                 gotAddr[i], gotData[i], expAddr(b, i), model[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] b = 18'($urandom);
    int n = 0;
    int cyc = 0;
    @(negedge clock);
    start = 1'b1; base_addr = b;
    @(negedge clock);
    start = 1'b0;
    while (cyc < 100) begin
      if (w_en) n++;
      if (n == 10) break;
      @(negedge clock);
      cyc++;
    end
    testsRun++;
    if (n !== 10) begin
      failCount++;
      $display("[TB] FAIL rstmid_reach: %0d writes seen, expected 10", n);
    end
    reset = 1'b1;
    #1;
    testsRun++;
    if (w_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_addr !== 18'h0) begin
      failCount++;
      $display("[TB] FAIL rstmid_drop: w_en=%b busy=%b done=%b w_addr=%h, expected 0 0 0 00000",
               w_en, busy, done, w_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    testsRun++;
    if (w_en !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_idle: w_en=%b busy=%b, expected 0 0", w_en, busy);
    end
    runBlock(b, 1'b0, 1'b0, '0, -1, 0);
    testsRun++;
    if (gotAddr.size() !== 64 || doneCnt !== 1 || doneIdx !== lastWenIdx + 1) begin
      failCount++;
      $display("[TB] FAIL rstmid_rerun: %0d writes %0d done, expected 64 and 1", gotAddr.size(), doneCnt);
    end
    for (int i = 0; i < gotAddr.size() && i < 64; i++) begin
      testsRun++;
      if (gotAddr[i] !== expAddr(b, i) || gotData[i] !== model[i]) begin
        failCount++;
        $display("[TB] FAIL rstmid_word%0d: addr=%h data=%h, expected addr=%h data=%h", i,
                 gotAddr[i], gotData[i], expAddr(b, i), model[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [17:0] b = 18'($urandom);
      for (int r = 0; r < 8; r++) writeRow(r, randRow());
      repeat (2) writeRow(int'($urandom_range(0, 7)), randRow());
      runBlock(b, 1'b0, 1'b0, '0, -1, 0);
      testsRun++;
      if (gotAddr.size() !== 64 || doneCnt !== 1 || doneIdx !== lastWenIdx + 1) begin
        failCount++;
        $display("[TB] FAIL rand%0d_count: %0d writes %0d done at %0d, expected 64 and 1 after %0d",
                 it, gotAddr.size(), doneCnt, doneIdx, lastWenIdx);
      end
      for (int i = 0; i < gotAddr.size() && i < 64; i++) begin
        testsRun++;
        if (gotAddr[i] !== expAddr(b, i) || gotData[i] !== model[i]) begin
          failCount++;
          $display("[TB] FAIL rand%0d_word%0d: addr=%h data=%h, expected addr=%h data=%h", it, i,
                   gotAddr[i], gotData[i], expAddr(b, i), model[i]);
        end
      end
    end
  endtask

`ifdef SRAM_READY_EN
  task automatic test_stall();
    logic [17:0] b = 18'($urandom);
    int w;
    runBlock(b, 1'b0, 1'b0, '0, 5, 3);
    testsRun++;
    if (gotAddr.size() !== 67 || doneCnt !== 1 || doneIdx !== lastWenIdx + 1) begin
      failCount++;
      $display("[TB] FAIL stall_count: %0d w_en cycles %0d done, expected 67 and 1", gotAddr.size(), doneCnt);
    end
    for (int i = 0; i < gotAddr.size() && i < 67; i++) begin
      w = (i <= 5) ? i : ((i <= 8) ? 5 : i - 3);
      testsRun++;
      if (gotAddr[i] !== expAddr(b, w) || gotData[i] !== model[w]) begin
        failCount++;
        $display("[TB] FAIL stall_cycle%0d: addr=%h data=%h, expected addr=%h data=%h", i,
                 gotAddr[i], gotData[i], expAddr(b, w), model[w]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_and_write();
    test_same_cycle();
    test_wrap();
    test_ignore_busy();
    test_reset_mid();
    test_random();
`ifdef SRAM_READY_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
